ws2812_rx: RTL

Single-wire WS2812 receiver/decoder. Samples a WS2812-format serial line, measures pulse high times to recover bits, assembles MSB-first 24-bit GRB words, and presents each word with its LED index using the same `rgb_data`/`led_num`/`write` signalling the `ws2812` transmitter accepts. It sits at the board input for daisy-chain sniffing and loopback testing. Its outputs drive a `ws2812` write port directly, so a received frame can be regenerated.

---
 rtl/ws2812_pkg.sv | 18 +
 rtl/ws2812_rx_edge.sv | 34 +++
 rtl/ws2812_rx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: default 12 MHz timing, colour word width and
// the receiver state encoding.
package ws2812_pkg;

    localparam int COLOR_W            = 24;
    localparam int T_ON_DEFAULT       = 10;
    localparam int T_OFF_DEFAULT      = 5;
    localparam int T_RESET_TX_DEFAULT = 600;
    localparam int T_RESET_RX_DEFAULT = 600;

    typedef enum logic [1:0] {
        RX_SYNC,
        RX_IDLE,
        RX_HIGH,
        RX_LOW
    } rx_state_t;

endpackage

// File: rtl/ws2812_rx_edge.sv
// Two-flop synchronizer followed by a registered rise/fall detector for a
// single asynchronous serial line.
module ws2812_rx_edge
    import ws2812_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // edge stage: level and its edge pulses update together
            level   <= sync_p1;
            rise    <= sync_p1 & ~level;
            fall    <= ~sync_p1 & level;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: measures high times, assembles MSB-first GRB
// words and presents them with a counting-down LED index.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int T_THRESH   = 8,
    parameter int T_MIN_HIGH = 2,
    parameter int T_MAX_HIGH = 20,
    parameter int T_RESET    = T_RESET_RX_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    output logic [COLOR_W-1:0] rgb_data,
    output logic [7:0]         led_num,
    output logic               write,
    output logic               frame_done,
    output logic               error
);

    // Counters are cleared on the edge that starts a level, so the level has
    // lasted (count + 1) clocks when its ending edge is seen, and at least
    // (count + 2) clocks on a cycle where no ending edge arrives.
    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [9:0] HI_ONE   = 10'(T_THRESH - 1);
    localparam logic [9:0] HI_MIN   = 10'(T_MIN_HIGH - 1);
    localparam logic [9:0] HI_MAX   = 10'(T_MAX_HIGH - 1);
    localparam logic [9:0] LOW_END  = 10'(T_RESET - 2);
    localparam logic [8:0] WORD_TOP = 9'(NUM_LEDS - 1);
    localparam logic [7:0] LED_TOP  = 8'(NUM_LEDS - 1);

    function automatic logic [9:0] sat_inc(input logic [9:0] c);
        return (c == CNT_MAX) ? c : c + 10'd1;
    endfunction

    logic rise_p2;
    logic fall_p2;
    logic level_p2;

    ws2812_rx_edge u_edge (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .rise  (rise_p2),
        .fall  (fall_p2),
        .level (level_p2)
    );

    rx_state_t          state;
    logic               from_low;
    logic [9:0]         cnt;
    logic [9:0]         hcnt;
    logic [4:0]         bit_cnt;
    logic [8:0]         word_cnt;
    logic               ovf;
    logic               got_bit;
    logic [COLOR_W-1:0] shreg;

    logic               bit_val;
    logic               bit_accept;
    logic               full;
    logic [COLOR_W-1:0] word_nxt;

    always_comb begin
        bit_val    = (hcnt >= HI_ONE);
        word_nxt   = {shreg[COLOR_W-2:0], bit_val};
        bit_accept = (state == RX_HIGH) && fall_p2 && (hcnt >= HI_MIN);
        full       = (word_cnt == 9'(NUM_LEDS));
    end

    always_ff @(posedge clk) begin
        if (bit_accept) begin
            shreg <= word_nxt;
        end
    end

    // decode stage: one cycle after the edge pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RX_SYNC;
            from_low   <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            ovf        <= 1'b0;
            got_bit    <= 1'b0;
            rgb_data   <= '0;
            led_num    <= LED_TOP;
            write      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            write      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            cnt        <= sat_inc(cnt);
            hcnt       <= sat_inc(hcnt);

            case (state)
                RX_SYNC: begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    ovf      <= 1'b0;
                    got_bit  <= 1'b0;
                    led_num  <= LED_TOP;
                    if (level_p2 || fall_p2) begin
                        cnt <= '0;
                    end else if (cnt >= LOW_END) begin
                        state <= RX_IDLE;
                    end
                end

                RX_IDLE: begin
                    if (rise_p2) begin
                        state    <= RX_HIGH;
                        hcnt     <= '0;
                        from_low <= 1'b0;
                    end
                end

                RX_HIGH: begin
                    if (fall_p2) begin
                        if (hcnt < HI_MIN) begin
                            // glitch: resume where we were, low count untouched
                            state <= from_low ? RX_LOW : RX_IDLE;
                        end else begin
                            state   <= RX_LOW;
                            cnt     <= '0;
                            got_bit <= 1'b1;
                            if (bit_cnt == 5'(COLOR_W - 1)) begin
                                bit_cnt <= '0;
                                if (!full) begin
                                    write    <= 1'b1;
                                    rgb_data <= word_nxt;
                                    led_num  <= 8'(WORD_TOP - word_cnt);
                                    word_cnt <= word_cnt + 9'd1;
                                end else if (!ovf) begin
                                    error <= 1'b1;
                                    ovf   <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else if (hcnt >= HI_MAX) begin
                        error <= 1'b1;
                        state <= RX_SYNC;
                        cnt   <= '0;
                    end
                end

                RX_LOW: begin
                    if (rise_p2) begin
                        state    <= RX_HIGH;
                        hcnt     <= '0;
                        from_low <= 1'b1;
                    end else if (cnt >= LOW_END) begin
                        frame_done <= got_bit;
                        error      <= (bit_cnt != 5'd0);
                        bit_cnt    <= '0;
                        word_cnt   <= '0;
                        ovf        <= 1'b0;
                        got_bit    <= 1'b0;
                        led_num    <= LED_TOP;
                        state      <= RX_IDLE;
                    end
                end

                default: state <= RX_SYNC;
            endcase
        end
    end

endmodule
